// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the hardwired ALUSystem sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {FETCH_L, FETCH_H, DECODE, EXEC1, EXEC2, HALT} state_e;

    localparam logic [3:0] OP_LD  = 4'h0;
    localparam logic [3:0] OP_ST  = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_INC = 4'h4;
    localparam logic [3:0] OP_BRA = 4'h5;
    localparam logic [3:0] OP_BNE = 4'h6;
    localparam logic [3:0] OP_NOP = 4'h7;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    localparam logic [1:0] ARF_PC = 2'd0;
    localparam logic [1:0] ARF_AR = 2'd1;
    localparam logic [1:0] ARF_SP = 2'd2;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_PASS_B = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0100;

    typedef struct packed {
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
        logic [1:0] rf_funsel;
        logic [1:0] arf_funsel;
        logic [1:0] ir_funsel;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] arf_regsel;
        logic [3:0] alu_funsel;
        logic [1:0] arf_outasel;
        logic [1:0] arf_outbsel;
        logic       ir_lh;
        logic       ir_enable;
        logic       mem_wr;
        logic       mem_cs;
        logic       muxcsel;
        logic [1:0] muxasel;
        logic [1:0] muxbsel;
    } ctrl_t;

    // Memory chip select is active-low, so the idle word keeps it high.
    localparam ctrl_t CTRL_IDLE = '{mem_cs: 1'b1, default: '0};

    // Write enables are MSB-first: index 0 maps to 4'b1000.
    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b1000 >> i;
    endfunction

endpackage

// File: rtl/cpu_sequencer_seq_timer.sv
// seq_timer: one-hot step counter with synchronous clear-to-T[0], advance and hold.
module seq_timer #(
    parameter int T_W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic           adv_i,
    input  logic           hold_i,
    output logic [T_W-1:0] t_o
);

    logic [T_W-1:0] t_q, t_d;

    always_comb t_d = clr_i ? T_W'(1) : (hold_i || !adv_i) ? t_q : {t_q[T_W-2:0], t_q[T_W-1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) t_q <= T_W'(1);
        else       t_q <= t_d;
    end

    assign t_o = t_q;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: hardwired control unit driving every ALUSystem control input.
// Outputs decode only state and latched-field flops, never IROut directly.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int         T_W     = 8,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [15:0]    IROut,
    input  logic [3:0]     ALUOutFlag,
    output logic [2:0]     RF_O1Sel,
    output logic [2:0]     RF_O2Sel,
    output logic [1:0]     RF_FunSel,
    output logic [1:0]     ARF_FunSel,
    output logic [1:0]     IR_Funsel,
    output logic [3:0]     RF_RSel,
    output logic [3:0]     RF_TSel,
    output logic [3:0]     ARF_RegSel,
    output logic [3:0]     ALU_FunSel,
    output logic [1:0]     ARF_OutASel,
    output logic [1:0]     ARF_OutBSel,
    output logic           IR_LH,
    output logic           IR_Enable,
    output logic           Mem_WR,
    output logic           Mem_CS,
    output logic           MuxCSel,
    output logic [1:0]     MuxASel,
    output logic [1:0]     MuxBSel,
    output logic [T_W-1:0] T,
    output logic           Halted
);

    state_e         state_q, state_d;
    logic           rst_q;
    logic [3:0]     op_q;
    logic [1:0]     rsel_q, dst_q;
    logic           z_q;
    logic [T_W-1:0] t_w;
    ctrl_t          c;
    logic           unused;

    assign unused = ^{IROut[7:0], ALUOutFlag[2:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_L: state_d = FETCH_H;
            FETCH_H: state_d = DECODE;
            DECODE:  state_d = (IROut[15:12] == HALT_OP) ? HALT : EXEC1;
            EXEC1:   state_d = (op_q == OP_ST) ? EXEC2 : FETCH_L;
            EXEC2:   state_d = FETCH_L;
            HALT:    state_d = HALT;
            default: state_d = FETCH_L;
        endcase
        if (rst_q) state_d = FETCH_L;
    end

    // rst_q stretches the clear word over the cycle after each sampled Reset.
    always_ff @(posedge Clock) begin
        rst_q <= Reset;
        if (Reset) begin
            state_q <= FETCH_L;
            op_q    <= '0;
            rsel_q  <= '0;
            dst_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q   <= IROut[15:12];
                rsel_q <= IROut[11:10];
                dst_q  <= IROut[9:8];
                z_q    <= ALUOutFlag[3];
            end
        end
    end

    seq_timer #(.T_W(T_W)) u_timer (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .clr_i  (state_d == FETCH_L),
        .adv_i  (state_q != HALT),
        .hold_i (state_d == HALT),
        .t_o    (t_w)
    );

    always_comb begin
        c = CTRL_IDLE;
        case (state_q)
            FETCH_L, FETCH_H: begin
                c.arf_outbsel = ARF_PC;
                c.mem_cs      = 1'b0;
                c.ir_enable   = 1'b1;
                c.ir_lh       = (state_q == FETCH_H);
                c.ir_funsel   = FS_LOAD;
                c.arf_regsel  = onehot(ARF_PC);
                c.arf_funsel  = FS_INC;
            end
            EXEC1: begin
                case (op_q)
                    OP_LD: begin
                        c.muxasel   = 2'b01;
                        c.rf_funsel = FS_LOAD;
                        c.rf_rsel   = onehot(rsel_q);
                    end
                    OP_ST: begin
                        c.muxbsel    = 2'b01;
                        c.arf_funsel = FS_LOAD;
                        c.arf_regsel = onehot(ARF_AR);
                    end
                    OP_MOV, OP_ADD: begin
                        c.rf_o1sel   = {1'b0, rsel_q};
                        c.rf_o2sel   = (op_q == OP_ADD) ? {1'b0, dst_q} : 3'b000;
                        c.alu_funsel = (op_q == OP_ADD) ? ALU_ADD : ALU_PASS_A;
                        c.muxasel    = 2'b00;
                        c.rf_rsel    = onehot(dst_q);
                        c.rf_funsel  = FS_LOAD;
                    end
                    OP_INC: begin
                        c.rf_funsel = FS_INC;
                        c.rf_rsel   = onehot(rsel_q);
                    end
                    OP_BRA, OP_BNE: begin
                        if (op_q == OP_BRA || !z_q) begin
                            c.muxbsel    = 2'b01;
                            c.arf_regsel = onehot(ARF_PC);
                            c.arf_funsel = FS_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
            EXEC2: begin
                c.arf_outbsel = ARF_AR;
                c.rf_o2sel    = {1'b0, rsel_q};
                c.alu_funsel  = ALU_PASS_B;
                c.mem_cs      = 1'b0;
                c.mem_wr      = 1'b1;
            end
            default: ;
        endcase
        if (rst_q) begin
            c            = CTRL_IDLE;
            c.arf_regsel = 4'b1111;
            c.arf_funsel = FS_CLR;
            c.rf_rsel    = 4'b1111;
            c.rf_tsel    = 4'b1111;
            c.rf_funsel  = FS_CLR;
        end
    end

    assign RF_O1Sel    = c.rf_o1sel;
    assign RF_O2Sel    = c.rf_o2sel;
    assign RF_FunSel   = c.rf_funsel;
    assign ARF_FunSel  = c.arf_funsel;
    assign IR_Funsel   = c.ir_funsel;
    assign RF_RSel     = c.rf_rsel;
    assign RF_TSel     = c.rf_tsel;
    assign ARF_RegSel  = c.arf_regsel;
    assign ALU_FunSel  = c.alu_funsel;
    assign ARF_OutASel = c.arf_outasel;
    assign ARF_OutBSel = c.arf_outbsel;
    assign IR_LH       = c.ir_lh;
    assign IR_Enable   = c.ir_enable;
    assign Mem_WR      = c.mem_wr;
    assign Mem_CS      = c.mem_cs;
    assign MuxCSel     = c.muxcsel;
    assign MuxASel     = c.muxasel;
    assign MuxBSel     = c.muxbsel;
    assign T           = (state_q == HALT) ? '0 : t_w;
    assign Halted      = (state_q == HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed instruction sequences; a scoreboard queue holds the
// expected control word per cycle and a negedge monitor compares the whole word.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_O1Sel, RF_O2Sel;
    logic [1:0]  RF_FunSel, ARF_FunSel, IR_Funsel;
    logic [3:0]  RF_RSel, RF_TSel, ARF_RegSel, ALU_FunSel;
    logic [1:0]  ARF_OutASel, ARF_OutBSel, MuxASel, MuxBSel;
    logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted;
    logic [7:0]  T;

    typedef struct packed {
        logic [7:0] t;
        logic       halted;
        logic [2:0] o1, o2;
        logic [1:0] rf_fs, arf_fs, ir_fs;
        logic [3:0] rsel, tsel, regsel, alu;
        logic [1:0] outa, outb;
        logic       ir_lh, ir_en, wr, cs, muxc;
        logic [1:0] muxa, muxb;
    } word_t;

    typedef struct {
        string name;
        word_t w;
    } exp_t;

    exp_t  sb[$];
    exp_t  x;
    word_t act;
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .Clock(clk), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel), .RF_FunSel(RF_FunSel),
        .ARF_FunSel(ARF_FunSel), .IR_Funsel(IR_Funsel), .RF_RSel(RF_RSel),
        .RF_TSel(RF_TSel), .ARF_RegSel(ARF_RegSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .IR_LH(IR_LH),
        .IR_Enable(IR_Enable), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxCSel(MuxCSel),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .T(T), .Halted(Halted)
    );

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            x   = sb.pop_front();
            act = {T, Halted, RF_O1Sel, RF_O2Sel, RF_FunSel, ARF_FunSel, IR_Funsel,
                   RF_RSel, RF_TSel, ARF_RegSel, ALU_FunSel, ARF_OutASel, ARF_OutBSel,
                   IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, MuxASel, MuxBSel};
            n_cmp++;
            if (act !== x.w) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", x.name, act, x.w);
            end
        end
    end

    function automatic word_t idle(input logic [7:0] t);
        word_t w = '0;
        w.t  = t;
        w.cs = 1'b1;
        return w;
    endfunction

    function automatic word_t fetch(input logic hi);
        word_t w = idle(hi ? 8'h02 : 8'h01);
        w.cs     = 1'b0;
        w.ir_en  = 1'b1;
        w.ir_lh  = hi;
        w.ir_fs  = 2'b10;
        w.regsel = 4'b1000;
        w.arf_fs = 2'b01;
        return w;
    endfunction

    function automatic word_t clr();
        word_t w = idle(8'h01);
        w.regsel = 4'b1111;
        w.arf_fs = 2'b11;
        w.rsel   = 4'b1111;
        w.tsel   = 4'b1111;
        w.rf_fs  = 2'b11;
        return w;
    endfunction

    task automatic step(input string nm, input word_t w);
        @(posedge clk);
        #1;
        sb.push_back('{name: nm, w: w});
    endtask

    task automatic instr(input string nm, input logic [15:0] ir, input word_t e1);
        IROut = ir;
        step({nm, "_fh"}, fetch(1'b1));
        step({nm, "_dec"}, idle(8'h04));
        step({nm, "_ex1"}, e1);
        step({nm, "_fl"}, fetch(1'b0));
    endtask

    word_t e, e2;

    initial begin
        Reset      = 1'b1;
        IROut      = 16'h0000;
        ALUOutFlag = 4'b0000;
        step("rst0", clr());
        step("rst1", clr());
        Reset = 1'b0;
        step("rst_rel", fetch(1'b0));

        e = idle(8'h08); e.muxa = 2'b01; e.rf_fs = 2'b10; e.rsel = 4'b0100;
        instr("ld", 16'h0512, e);

        IROut = 16'h1030;
        e  = idle(8'h08); e.muxb = 2'b01; e.arf_fs = 2'b10; e.regsel = 4'b0100;
        e2 = idle(8'h10); e2.outb = 2'b01; e2.o2 = 3'b000; e2.alu = 4'b0001; e2.cs = 1'b0; e2.wr = 1'b1;
        step("st_fh", fetch(1'b1));
        step("st_dec", idle(8'h04));
        step("st_ex1", e);
        step("st_ex2", e2);
        step("st_fl", fetch(1'b0));

        e = idle(8'h08); e.o1 = 3'b010; e.rsel = 4'b0001; e.rf_fs = 2'b10;
        instr("mov", 16'h2B00, e);

        e = idle(8'h08); e.o1 = 3'b001; e.o2 = 3'b010; e.alu = 4'b0100; e.rsel = 4'b0010; e.rf_fs = 2'b10;
        instr("add", 16'h3600, e);

        e = idle(8'h08); e.rf_fs = 2'b01; e.rsel = 4'b0001;
        instr("inc", 16'h4C00, e);

        e = idle(8'h08); e.muxb = 2'b01; e.regsel = 4'b1000; e.arf_fs = 2'b10;
        instr("bra", 16'h5044, e);
        ALUOutFlag = 4'b0000;
        instr("bne_taken", 16'h6020, e);
        ALUOutFlag = 4'b1000;
        instr("bne_not", 16'h6020, idle(8'h08));
        ALUOutFlag = 4'b0000;

        instr("nop", 16'h7000, idle(8'h08));
        instr("op9_nop", 16'h9000, idle(8'h08));

        IROut = 16'hF000;
        step("hlt_fh", fetch(1'b1));
        step("hlt_dec", idle(8'h04));
        e = idle(8'h00); e.halted = 1'b1;
        for (int i = 0; i < 20; i++) step("halt_hold", e);
        Reset = 1'b1;
        step("halt_rst", clr());
        Reset = 1'b0;
        step("halt_rel", fetch(1'b0));

        IROut = 16'h1030;
        e = idle(8'h08); e.muxb = 2'b01; e.arf_fs = 2'b10; e.regsel = 4'b0100;
        step("mst_fh", fetch(1'b1));
        step("mst_dec", idle(8'h04));
        step("mst_ex1", e);
        Reset = 1'b1;
        step("mst_rst", clr());
        Reset = 1'b0;
        step("mst_fl", fetch(1'b0));
        step("mst_fh2", fetch(1'b1));

        @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Hardwired control unit for ALUSystem (RF, ARF, IR, ALU, memory, MuxA/B/C).
- Drives every ALUSystem control input on every cycle and exports the one-hot timing vector T, so CPUSystem consists of ALUSystem plus this block.
- Implements fetch (two bytes into IR), decode and a 1–2 cycle execute for an 8-opcode subset.

Parameters:
- T_W, 8, width of the one-hot timing vector T.
- HALT_OP, 4'hF, opcode that stops the sequencer.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high.
- IROut  in  16  instruction register contents: [15:12] opcode, [11:10] RSEL, [9:8] DSTREG, [7:0] ADDRESS.
- ALUOutFlag  in  4  flags {Z,C,N,O}, bit 3 = Z.
- RF_O1Sel, RF_O2Sel  out  3 each.
- RF_FunSel, ARF_FunSel, IR_Funsel  out  2 each.
- RF_RSel, RF_TSel, ARF_RegSel  out  4 each.
- ALU_FunSel  out  4.
- ARF_OutASel, ARF_OutBSel  out  2 each.
- IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel  out  1 each.
- MuxASel, MuxBSel  out  2 each.
- T  out  8  one-hot step counter; T[0] is the first fetch cycle.
- Halted  out  1  high while in the HALT state.

Behaviour:
- Register FunSel encoding: 00 decrement, 01 increment, 10 load, 11 clear.
- RSel, TSel and RegSel are one-hot write enables; 0000 means no write.
- Memory: Mem_CS = 0 selects the memory; Mem_WR = 1 writes.
- Idle control word (every output not listed for a state): all select/enable fields 0, Mem_CS = 1, Mem_WR = 0, IR_Enable = 0, ALU_FunSel = 0000.
- FSM states: FETCH_L, FETCH_H, DECODE, EXEC1, EXEC2, HALT.
- T is one-hot with T[n] = step n of the current instruction:
  - FETCH_L = T[0], FETCH_H = T[1], DECODE = T[2], EXEC1 = T[3], EXEC2 = T[4].
  - T is 0 in HALT.
  - T returns to T[0] after the last execute step.
- Reset (sampled on a rising Clock, regardless of state or mid-instruction):
  - next state FETCH_L, T = 0000_0001, Halted = 0.
  - For that one cycle, ARF_RegSel = 1111, ARF_FunSel = 11, RF_RSel = 1111, RF_TSel = 1111, RF_FunSel = 11.
  - Effect: PC, AR, SP and all RF registers clear on the next edge.
- FETCH_L:
  - ARF_OutBSel = PC, Mem_CS = 0, Mem_WR = 0, IR_Enable = 1, IR_LH = 0, IR_Funsel = 10 (load low byte).
  - Also ARF_RegSel = PC only, ARF_FunSel = 01 (PC+1).
- FETCH_H: same as FETCH_L with IR_LH = 1 (load high byte).
- DECODE: idle word; opcode latched internally from IROut[15:12].
- EXEC by opcode (src/dst registers from RSEL/DSTREG; RF_RSel = one-hot(RSEL)):
  - 0 LD (EXEC1, then FETCH_L): MuxASel = 01 (IROut[7:0]), RF_FunSel = 10.
  - 1 ST: EXEC1 loads AR from ADDRESS (MuxBSel = 01, ARF_FunSel = 10). EXEC2 drives ARF_OutBSel = AR, RF_O2Sel = RSEL, ALU_FunSel = 0001 (pass B), Mem_CS = 0, Mem_WR = 1.
  - 2 MOV (EXEC1): RF_O1Sel = RSEL, ALU_FunSel = 0000 (pass A), MuxASel = 00 (ALUOut), RF_RSel = one-hot(DSTREG), RF_FunSel = 10.
  - 3 ADD (EXEC1): O1 = RSEL, O2 = DSTREG, ALU_FunSel = 0100, result to DSTREG.
  - 4 INC (EXEC1): RF_FunSel = 01 on RSEL.
  - 5 BRA (EXEC1): MuxBSel = 01, ARF_RegSel = PC, ARF_FunSel = 10.
  - 6 BNE (EXEC1): as BRA only if ALUOutFlag[3] = 0 at EXEC1; otherwise idle word.
  - 7 NOP (EXEC1): idle word.
  - 8–E: treated as NOP.
  - F (from DECODE): go to HALT.
- HALT: idle word, Halted = 1; only Reset leaves HALT.
- Cycle counts (fetch, decode and execute are a fixed schedule): LD, MOV, ADD, INC, BRA, BNE and NOP take 4 cycles; ST takes 5.
- All outputs are registered, i.e. driven directly from state flops and the latched opcode/field registers. No combinational path from IROut to outputs.
- Field latching: opcode is latched at DECODE; RSEL, DSTREG and ADDRESS are used from the latched copy in EXEC1/EXEC2.

Decomposition:
- Package cpu_pkg:
  - state enum;
  - opcode constants;
  - FunSel encodings (DEC, INC, LOAD, CLR);
  - ARF register indices (PC, AR, SP);
  - ALU function codes;
  - the idle control-word constant.
- One sub-module, seq_timer: one-hot T counter with synchronous clear, advance and hold inputs.

Test Plan:
- Reset reset check: Reset held high 2 cycles, then low.
  - During Reset: clear word on ARF and RF.
  - Cycle after release: T = 0000_0001, Mem_CS = 0, IR_LH = 0.
- LD: IR = 16'h0512 (LD, RSEL = 1).
  - T steps 01→02→04→08→01.
  - In EXEC1: MuxASel = 01, RF_FunSel = 10, RF_RSel = 0100.
- ST: IR = 16'h1030.
  - EXEC1: ARF_FunSel = 10.
  - EXEC2: Mem_WR = 1, Mem_CS = 0, ARF_OutBSel = AR.
  - Next fetch 5 cycles after T[0].
- BNE taken vs not: IR = 16'h6020.
  - With ALUOutFlag = 4'b0000: ARF PC load.
  - With ALUOutFlag = 4'b1000: idle word in EXEC1, ARF_RegSel = 0000.
- HLT: IR = 16'hF000.
  - After DECODE: Halted = 1, T = 0; holds 20 cycles.
  - Reset returns to FETCH_L.
- Reset mid-ST asserted during EXEC1:
  - Next cycle is FETCH_L.
  - Mem_WR never asserted.
